uart_program_loader: RTL and testbench

UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

---
 rtl/uart_program_loader.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_program_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// UART program loader: receives an 8N1 byte stream, checks the framing
// (A5, little-endian word count, data words, XOR checksum), writes each
// assembled instruction word into the ITCM and releases the core reset
// once a complete, checksum-verified program has been loaded.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 1476,
  parameter int ITCM_WORDS   = 1024
) (
  input  logic        clk,
  input  logic        cpu_rst,
  input  logic        uart_rx,
  output logic        itcm_we,
  output logic [11:0] itcm_addr,
  output logic [31:0] itcm_wdata,
  output logic        core_rst,
  output logic        load_done,
  output logic        load_error
);

  localparam int BCW = $clog2(CLKS_PER_BIT + 1);
  localparam int WW  = $clog2(ITCM_WORDS + 1);
  localparam logic [BCW-1:0] HALF_M1 = BCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCW-1:0] FULL_M1 = BCW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]     SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR} ld_state_t;

  // Running checksum update: XOR of every length and data byte.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  logic            rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  rx_state_t       rx_state_q, rx_state_d;
  logic            rx_armed_q, rx_armed_d;
  logic [BCW-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  ld_state_t       ld_state_q, ld_state_d;
  logic [15:0]     len_q, len_d;
  logic [WW-1:0]   word_idx_q, word_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [23:0]     word_buf_q, word_buf_d;
  logic [7:0]      csum_q, csum_d;
  logic            itcm_we_q, itcm_we_d;
  logic [11:0]     itcm_addr_q, itcm_addr_d;
  logic [31:0]     itcm_wdata_q, itcm_wdata_d;
  logic            core_rst_q, core_rst_d;
  logic            load_done_q, load_done_d;
  logic            load_error_q, load_error_d;
  logic [15:0]     len_next_s;

  // Receiver: synchronizer, start-bit qualification, bit sampling and stop check.
  always_comb begin
    rx_meta_d    = uart_rx;
    rx_sync_d    = rx_meta_q;
    rx_state_d   = rx_state_q;
    rx_armed_d   = rx_armed_q;
    baud_cnt_d   = baud_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        baud_cnt_d = '0;
        bit_idx_d  = 3'd0;
        // A start bit is only accepted once the line has been seen idle high.
        if (rx_armed_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_armed_d = 1'b0;
        end else begin
          rx_armed_d = rx_sync_q;
        end
      end
      RX_START: begin
        if (baud_cnt_q == HALF_M1) begin
          baud_cnt_d = '0;
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (baud_cnt_q == FULL_M1) begin
          baud_cnt_d = '0;
          shift_d    = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (baud_cnt_q == FULL_M1) begin
          baud_cnt_d = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // Loader FSM: protocol parsing, word assembly, ITCM writes and status outputs.
  always_comb begin
    ld_state_d   = ld_state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    word_buf_d   = word_buf_q;
    csum_d       = csum_q;
    itcm_we_d    = 1'b0;
    itcm_addr_d  = itcm_addr_q;
    itcm_wdata_d = itcm_wdata_q;
    len_next_s   = {shift_q, len_q[7:0]};
    if (frame_err_q) begin
      if (ld_state_q != S_SYNC) begin
        ld_state_d = S_ERROR;
      end else begin
        ld_state_d = ld_state_q;
      end
    end else if (byte_valid_q) begin
      case (ld_state_q)
        S_SYNC, S_DONE, S_ERROR: begin
          if (shift_q == SYNC_BYTE) begin
            ld_state_d = S_LEN_LO;
            csum_d     = 8'h00;
            len_d      = 16'h0000;
            word_idx_d = '0;
            byte_idx_d = 2'd0;
          end else begin
            ld_state_d = ld_state_q;
          end
        end
        S_LEN_LO: begin
          len_d      = {8'h00, shift_q};
          csum_d     = csum_next(csum_q, shift_q);
          ld_state_d = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d  = len_next_s;
          csum_d = csum_next(csum_q, shift_q);
          if (32'(len_next_s) > 32'(ITCM_WORDS)) begin
            ld_state_d = S_ERROR;
          end else if (len_next_s == 16'h0000) begin
            ld_state_d = S_CHECK;
          end else begin
            ld_state_d = S_DATA;
          end
        end
        S_DATA: begin
          csum_d = csum_next(csum_q, shift_q);
          if (byte_idx_q == 2'd3) begin
            // Fourth byte completes the word; the strobe appears next cycle.
            itcm_we_d    = 1'b1;
            itcm_addr_d  = 12'(32'(word_idx_q) << 2);
            itcm_wdata_d = {shift_q, word_buf_q};
            byte_idx_d   = 2'd0;
            word_idx_d   = word_idx_q + 1'b1;
            if (32'(word_idx_q) + 32'd1 == 32'(len_q)) begin
              ld_state_d = S_CHECK;
            end else begin
              ld_state_d = S_DATA;
            end
          end else begin
            word_buf_d = {shift_q, word_buf_q[23:8]};
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
        S_CHECK: begin
          if (shift_q == csum_q) begin
            ld_state_d = S_DONE;
          end else begin
            ld_state_d = S_ERROR;
          end
        end
        default: begin
          ld_state_d = S_SYNC;
        end
      endcase
    end else begin
      ld_state_d = ld_state_q;
    end
    // Status follows the next state so core_rst drops on the very edge DONE is entered.
    core_rst_d   = (ld_state_d != S_DONE);
    load_done_d  = (ld_state_d == S_DONE);
    load_error_d = (ld_state_d == S_ERROR);
  end

  // State register for receiver and loader; cpu_rst low aborts everything asynchronously.
  always_ff @(posedge clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_armed_q   <= 1'b0;
      baud_cnt_q   <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ld_state_q   <= S_SYNC;
      len_q        <= 16'h0000;
      word_idx_q   <= '0;
      byte_idx_q   <= 2'd0;
      word_buf_q   <= 24'h000000;
      csum_q       <= 8'h00;
      itcm_we_q    <= 1'b0;
      itcm_addr_q  <= 12'h000;
      itcm_wdata_q <= 32'h00000000;
      core_rst_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_state_q   <= rx_state_d;
      rx_armed_q   <= rx_armed_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ld_state_q   <= ld_state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_buf_q   <= word_buf_d;
      csum_q       <= csum_d;
      itcm_we_q    <= itcm_we_d;
      itcm_addr_q  <= itcm_addr_d;
      itcm_wdata_q <= itcm_wdata_d;
      core_rst_q   <= core_rst_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign itcm_we    = itcm_we_q;
  assign itcm_addr  = itcm_addr_q;
  assign itcm_wdata = itcm_wdata_q;
  assign core_rst   = core_rst_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: UART byte streams are driven serially,
// expected ITCM writes are queued when a stream is sent and checked when the
// DUT strobes itcm_we; status outputs are checked after each stream.
module tb_uart_program_loader;
  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        uart_rx;
  logic        itcm_we;
  logic [11:0] itcm_addr;
  logic [31:0] itcm_wdata;
  logic        core_rst;
  logic        load_done;
  logic        load_error;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [43:0] exp_q[$];
  logic [43:0] mon_e;
  logic [7:0]  tx_q[$];

  uart_program_loader #(.CLKS_PER_BIT(CPB), .ITCM_WORDS(1024)) dut (
    .clk        (clk),
    .cpu_rst    (cpu_rst),
    .uart_rx    (uart_rx),
    .itcm_we    (itcm_we),
    .itcm_addr  (itcm_addr),
    .itcm_wdata (itcm_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .load_error (load_error)
  );

  // 10 ns core clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (itcm_we === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_bad++;
        $error("FAIL unexpected_write: observed addr 0x%0h data 0x%0h expected no write", itcm_addr, itcm_wdata);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 32'(itcm_addr), 32'(mon_e[43:32]));
        chk("write_data", itcm_wdata, mon_e[31:0]);
      end
    end
  end

  // Serial 8N1 transmit of one byte with a selectable stop bit, then two idle bit times.
  task automatic send_byte(input logic [7:0] b, input logic stop_b);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_b;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_all();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  // Two-word program; last argument is the checksum byte appended after the data.
  task automatic load_prog_stream(input logic [7:0] ck);
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    tx_q.push_back(ck);
  endtask

  // Reference checksum: XOR of length and data bytes (everything after the A5).
  function automatic logic [7:0] ref_csum();
    logic [7:0] c;
    c = 8'h00;
    for (int i = 1; i < 11; i++) c = c ^ tx_q[i];
    return c;
  endfunction

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_we"},    32'(itcm_we),    32'd0);
    chk({pfx, "_addr"},  32'(itcm_addr),  32'd0);
    chk({pfx, "_wdata"}, itcm_wdata,      32'd0);
    chk({pfx, "_core_rst"},   32'(core_rst),   32'd1);
    chk({pfx, "_load_done"},  32'(load_done),  32'd0);
    chk({pfx, "_load_error"}, 32'(load_error), 32'd0);
  endtask

  task automatic chk_status(input string pfx, input logic d, input logic e, input logic r);
    chk({pfx, "_load_done"},  32'(load_done),  32'(d));
    chk({pfx, "_load_error"}, 32'(load_error), 32'(e));
    chk({pfx, "_core_rst"},   32'(core_rst),   32'(r));
  endtask

  logic [7:0] good_ck;

  initial begin
    cpu_rst = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    cpu_rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // Good two-word load; the checksum covers 02 00 13 00 00 00 93 00 10 00 = 0x92.
    load_prog_stream(8'h00);
    good_ck = ref_csum();
    chk("ref_csum", 32'(good_ck), 32'h92);
    load_prog_stream(good_ck);
    exp_q.push_back({12'h000, 32'h00000013});
    exp_q.push_back({12'h004, 32'h00100093});
    while (tx_q.size() > 1) send_byte(tx_q.pop_front(), 1'b1);
    chk_status("good_before_ck", 1'b0, 1'b0, 1'b1);
    send_all();
    chk("good_writes_left", 32'(exp_q.size()), 32'd0);
    chk_status("good_end", 1'b1, 1'b0, 1'b0);

    // Same stream with a wrong checksum: writes still happen, then error.
    load_prog_stream(8'h91);
    exp_q.push_back({12'h000, 32'h00000013});
    exp_q.push_back({12'h004, 32'h00100093});
    send_byte(tx_q.pop_front(), 1'b1);
    chk_status("reload_after_a5", 1'b0, 1'b0, 1'b1);
    send_all();
    chk("badck_writes_left", 32'(exp_q.size()), 32'd0);
    chk_status("badck_end", 1'b0, 1'b1, 1'b1);

    // Oversized length 1025 -> error straight after the length bytes, no writes.
    send_byte(8'hA5, 1'b1);
    chk_status("len_after_a5", 1'b0, 1'b0, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h04, 1'b1);
    chk_status("len_too_big", 1'b0, 1'b1, 1'b1);

    // Stop bit low on the second data byte -> framing error.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    chk_status("frame_before", 1'b0, 1'b0, 1'b1);
    send_byte(8'h00, 1'b0);
    chk_status("frame_err", 1'b0, 1'b1, 1'b1);

    // Back to SYNC, then a one-cycle glitch must not start a byte.
    cpu_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset2");
    cpu_rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk_status("glitch", 1'b0, 1'b0, 1'b1);

    // Zero-length program with checksum 0x00 -> DONE, no writes; the stream
    // starts soon after the glitch so a glitch-started frame would corrupt it.
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_all();
    chk_status("zero_len", 1'b1, 1'b0, 1'b0);

    // Reset in the middle of the seventh byte of a load, then a full clean reload.
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
    send_all();
    chk_status("mid_data", 1'b0, 1'b0, 1'b1);
    uart_rx = 1'b0;
    repeat (CPB + 3) @(negedge clk);
    cpu_rst = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset3");
    cpu_rst = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    load_prog_stream(good_ck);
    exp_q.push_back({12'h000, 32'h00000013});
    exp_q.push_back({12'h004, 32'h00100093});
    send_all();
    chk("reload_writes_left", 32'(exp_q.size()), 32'd0);
    chk_status("reload_end", 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
